ad5628_frame_decoder: RTL and testbench

Receive-side model of the AD5628 serial interface, sitting directly downstream of the DAC SPI driver on its `sclk`/`cs`/`mosi` lines. It oversamples the SPI lines with the system clock and assembles 32-bit frames. It decodes the AD5628 command set and keeps the eight input and DAC registers plus the internal-reference bit. Its outputs feed the DAC-output checker and the board-level analog model.

---
 rtl/ad5628_pkg.sv | 51 +++++
 rtl/ad5628_frame_decoder_sync_edge_detect.sv | 47 ++++
 rtl/ad5628_frame_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_ad5628_frame_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad5628_pkg.sv
// Shared definitions for the AD5628 receive-side frame decoder:
// command codes, frame field positions, channel count and FSM states.
package ad5628_pkg;

    localparam int N_CH       = 8;
    localparam int FRAME_BITS = 32;
    localparam int DATA_W     = 12;
    localparam int CNT_W      = 6;

    // Bit counter values: a good frame lands exactly on CNT_FULL,
    // CNT_OVER is the saturation point that marks an overlong frame.
    localparam logic [CNT_W-1:0] CNT_FULL = 6'd32;
    localparam logic [CNT_W-1:0] CNT_OVER = 6'd33;

    // Field positions inside the 32-bit frame
    localparam int CMD_MSB  = 27;
    localparam int CMD_LSB  = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 20;
    localparam int DATA_MSB = 19;
    localparam int DATA_LSB = 8;
    localparam int REF_BIT  = 0;

    localparam logic [3:0] ADDR_ALL = 4'hF;

    typedef enum logic [3:0] {
        CMD_WR_IN      = 4'd0,
        CMD_UPD        = 4'd1,
        CMD_WR_UPD_ALL = 4'd2,
        CMD_WR_UPD     = 4'd3,
        CMD_REF        = 4'd8
    } cmd_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    // True for the command codes the decoder acts on
    function automatic logic cmdSupported(input logic [3:0] cmd);
        return (cmd == CMD_WR_IN) || (cmd == CMD_UPD) ||
               (cmd == CMD_WR_UPD_ALL) || (cmd == CMD_WR_UPD) ||
               (cmd == CMD_REF);
    endfunction

    // True when an address selects the given channel (directly or broadcast)
    function automatic logic addrHits(input logic [3:0] addr, input int ch);
        return (addr == ADDR_ALL) || (int'(addr) == ch);
    endfunction

endpackage

// File: rtl/ad5628_frame_decoder_sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous input, followed by a
// registered edge detector producing one-cycle rise/fall strobes.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    logic              w_level;

    assign w_level = r_chain[STAGES-1];

    // Synchronizer chain; clears to 0 so that a line already low when reset
    // drops (e.g. cs mid-frame) never looks like a fresh falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    // Registered edge strobes, one cycle behind the synchronized level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
            r_fall <= ~w_level & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/ad5628_frame_decoder.sv
// Receive-side model of the AD5628 SPI interface: oversamples sclk/cs/mosi,
// assembles 32-bit frames and maintains the input/DAC register file and
// internal-reference enable.
module ad5628_frame_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int N_CH        = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sclk,
    input  logic                 i_cs,
    input  logic                 i_mosi,
    output logic [N_CH*12-1:0]   o_dac_code,
    output logic                 o_ref_on,
    output logic                 o_frame_valid,
    output logic                 o_frame_err,
    output logic                 o_cmd_err,
    output logic [3:0]           o_last_cmd,
    output logic [3:0]           o_last_addr
);

    import ad5628_pkg::*;

    logic                  w_sclkRise;
    logic                  w_sclkFall;
    logic                  w_csRise;
    logic                  w_csFall;
    logic [SYNC_STAGES-1:0] r_mosiChain;
    logic                  r_mosiAligned;

    state_e                r_state;
    state_e                w_nextState;
    logic                  w_clear;
    logic                  w_shift;
    logic                  w_eval;

    logic [FRAME_BITS-1:0] r_frame;
    logic [CNT_W-1:0]      r_count;
    logic [FRAME_BITS-1:0] w_shiftedFrame;
    logic [CNT_W-1:0]      w_bumpedCount;
    logic [FRAME_BITS-1:0] w_evalFrame;
    logic [CNT_W-1:0]      w_evalCount;
    logic [3:0]            w_cmd;
    logic [3:0]            w_addr;
    logic [DATA_W-1:0]     w_data;
    logic                  w_addrValid;
    logic                  w_unusedBits;
    logic                  w_unusedSclkRise;

    logic [DATA_W-1:0]     r_inReg  [N_CH];
    logic [DATA_W-1:0]     r_dacReg [N_CH];
    logic                  r_refOn;
    logic                  r_frameValid;
    logic                  r_frameErr;
    logic                  r_cmdErr;
    logic [3:0]            r_lastCmd;
    logic [3:0]            r_lastAddr;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclkSync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_sclk),
        .o_rise  (w_sclkRise),
        .o_fall  (w_sclkFall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_csSync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_cs),
        .o_rise  (w_csRise),
        .o_fall  (w_csFall)
    );

    assign w_unusedSclkRise = w_sclkRise;

    // mosi synchronizer plus one extra flop so the sampled bit lines up with
    // the registered sclk falling-edge strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mosiChain   <= '0;
            r_mosiAligned <= 1'b0;
        end else begin
            r_mosiChain   <= {r_mosiChain[SYNC_STAGES-2:0], i_mosi};
            r_mosiAligned <= r_mosiChain[SYNC_STAGES-1];
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state: a cs fall opens a frame, a cs rise closes it
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (w_csFall) w_nextState = ST_SHIFT;
            ST_SHIFT: if (w_csRise) w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // FSM outputs: sclk edges only matter inside a frame, so they are
    // ignored entirely while idle (cs high)
    always_comb begin
        w_clear = 1'b0;
        w_shift = 1'b0;
        w_eval  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = w_csFall;
            end
            ST_SHIFT: begin
                w_shift = w_sclkFall;
                w_eval  = w_csRise;
            end
            default: ;
        endcase
    end

    // When the last sclk fall and the cs rise coincide, the evaluation must
    // see the frame and count as they will be after this cycle's shift.
    assign w_shiftedFrame = {r_frame[FRAME_BITS-2:0], r_mosiAligned};
    assign w_bumpedCount  = (r_count == CNT_OVER) ? CNT_OVER : r_count + 1'b1;
    assign w_evalFrame    = w_shift ? w_shiftedFrame : r_frame;
    assign w_evalCount    = w_shift ? w_bumpedCount  : r_count;

    assign w_cmd       = w_evalFrame[CMD_MSB:CMD_LSB];
    assign w_addr      = w_evalFrame[ADDR_MSB:ADDR_LSB];
    assign w_data      = w_evalFrame[DATA_MSB:DATA_LSB];
    assign w_addrValid = (int'(w_addr) < N_CH) || (w_addr == ADDR_ALL);
    assign w_unusedBits = ^{w_evalFrame[31:28], w_evalFrame[7:1]};

    // Shift register and saturating bit counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_frame <= '0;
            r_count <= '0;
        end else if (w_shift) begin
            r_frame <= w_shiftedFrame;
            r_count <= w_bumpedCount;
        end
    end

    // Frame evaluation: register file, reference bit, last_* and pulses.
    // Command 2 copies the freshly written value, so the hit channel is
    // loaded from the frame data rather than from the old input register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                r_inReg[ch]  <= '0;
                r_dacReg[ch] <= '0;
            end
            r_refOn      <= 1'b0;
            r_frameValid <= 1'b0;
            r_frameErr   <= 1'b0;
            r_cmdErr     <= 1'b0;
            r_lastCmd    <= '0;
            r_lastAddr   <= '0;
        end else begin
            r_frameValid <= 1'b0;
            r_frameErr   <= 1'b0;
            r_cmdErr     <= 1'b0;
            if (w_eval) begin
                if (w_evalCount == CNT_FULL) begin
                    r_frameValid <= 1'b1;
                    r_cmdErr     <= ~cmdSupported(w_cmd);
                    r_lastCmd    <= w_cmd;
                    r_lastAddr   <= w_addr;
                    if (w_cmd == CMD_REF) begin
                        r_refOn <= w_evalFrame[REF_BIT];
                    end else if (w_addrValid) begin
                        for (int ch = 0; ch < N_CH; ch++) begin
                            case (w_cmd)
                                CMD_WR_IN: begin
                                    if (addrHits(w_addr, ch)) r_inReg[ch] <= w_data;
                                end
                                CMD_UPD: begin
                                    if (addrHits(w_addr, ch)) r_dacReg[ch] <= r_inReg[ch];
                                end
                                CMD_WR_UPD_ALL: begin
                                    if (addrHits(w_addr, ch)) begin
                                        r_inReg[ch]  <= w_data;
                                        r_dacReg[ch] <= w_data;
                                    end else begin
                                        r_dacReg[ch] <= r_inReg[ch];
                                    end
                                end
                                CMD_WR_UPD: begin
                                    if (addrHits(w_addr, ch)) begin
                                        r_inReg[ch]  <= w_data;
                                        r_dacReg[ch] <= w_data;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end else begin
                    r_frameErr <= 1'b1;
                end
            end
        end
    end

    // Pack the DAC registers onto the flat output bus
    always_comb begin
        o_dac_code = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            o_dac_code[ch*DATA_W +: DATA_W] = r_dacReg[ch];
        end
    end

    assign o_ref_on      = r_refOn;
    assign o_frame_valid = r_frameValid;
    assign o_frame_err   = r_frameErr;
    assign o_cmd_err     = r_cmdErr;
    assign o_last_cmd    = r_lastCmd;
    assign o_last_addr   = r_lastAddr;

endmodule

// File: tb/tb_ad5628_frame_decoder.sv
// Directed, table-driven testbench for ad5628_frame_decoder, plus hand
// sequences for coincident edges, back-to-back frames and mid-frame reset.
module tb_ad5628_frame_decoder;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic [95:0] dacCode;
    logic        refOn;
    logic        frameValid;
    logic        frameErr;
    logic        cmdErr;
    logic [3:0]  lastCmd;
    logic [3:0]  lastAddr;

    int errCount   = 0;
    int checkCount = 0;
    int validTotal = 0;

    int          obsValid;
    int          obsErr;
    int          obsCmdErr;
    int          obsFirst;
    logic [95:0] obsDacAt3;

    typedef struct {
        string       name;
        logic [63:0] bits;
        int          nBits;
        int          expValid;
        int          expErr;
        int          expCmdErr;
        logic [95:0] expDac;
        logic        expRef;
        logic [3:0]  expCmd;
        logic [3:0]  expAddr;
    } vec_t;

    vec_t vecs[12];

    ad5628_frame_decoder #(.SYNC_STAGES(2), .N_CH(8)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sclk        (sclk),
        .i_cs          (cs),
        .i_mosi        (mosi),
        .o_dac_code    (dacCode),
        .o_ref_on      (refOn),
        .o_frame_valid (frameValid),
        .o_frame_err   (frameErr),
        .o_cmd_err     (cmdErr),
        .o_last_cmd    (lastCmd),
        .o_last_addr   (lastAddr)
    );

    // 100 MHz system clock; SPI runs at 80 ns per bit (8x slower)
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Running count of frame_valid pulses, used across overlapping frames
    always @(negedge clk) begin
        if (frameValid) validTotal <= validTotal + 1;
    end

    function automatic logic [95:0] dacVal(input logic [11:0] c0, c1, c2, c3,
                                           input logic [11:0] c4, c5, c6, c7);
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic vec_t mk(input string name, input logic [63:0] bits, input int n,
                                input int v, input int e, input int c,
                                input logic [95:0] dac, input logic r,
                                input logic [3:0] cmd, input logic [3:0] addr);
        vec_t t;
        t.name = name; t.bits = bits; t.nBits = n;
        t.expValid = v; t.expErr = e; t.expCmdErr = c;
        t.expDac = dac; t.expRef = r; t.expCmd = cmd; t.expAddr = addr;
        return t;
    endfunction

    task automatic checkValue(input string name, input logic [95:0] act, input logic [95:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Clock out n bits MSB first; optionally raise cs together with the last sclk fall
    task automatic sendBits(input logic [63:0] bits, input int n, input bit simul);
        @(negedge clk);
        cs = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            #40;
            sclk = 1'b0;
            if (simul && i == 0) begin
                cs = 1'b1;
            end else begin
                #40;
                sclk = 1'b1;
            end
        end
        if (!simul) begin
            #40;
            cs = 1'b1;
        end
    endtask

    // Observe 8 clock cycles after the cs rise: pulse counts, first pulse cycle, dac before update
    task automatic watchPulses();
        obsValid = 0; obsErr = 0; obsCmdErr = 0; obsFirst = 0; obsDacAt3 = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) obsDacAt3 = dacCode;
            if (frameValid) obsValid++;
            if (frameErr) obsErr++;
            if (cmdErr) obsCmdErr++;
            if ((frameValid || frameErr) && obsFirst == 0) obsFirst = k;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        sendBits(v.bits, v.nBits, 1'b0);
        watchPulses();
    endtask

    task automatic checkOutput(input vec_t v, input logic [95:0] prevDac);
        checkValue({v.name, " valid"},   96'(obsValid),  96'(v.expValid));
        checkValue({v.name, " err"},     96'(obsErr),    96'(v.expErr));
        checkValue({v.name, " cmdErr"},  96'(obsCmdErr), 96'(v.expCmdErr));
        checkValue({v.name, " latency"}, 96'(obsFirst),  96'((v.expValid + v.expErr) > 0 ? 4 : 0));
        checkValue({v.name, " dacPre"},  obsDacAt3,      prevDac);
        checkValue({v.name, " dac"},     dacCode,        v.expDac);
        checkValue({v.name, " ref"},     96'(refOn),     96'(v.expRef));
        checkValue({v.name, " lastCmd"}, 96'(lastCmd),   96'(v.expCmd));
        checkValue({v.name, " lastAddr"},96'(lastAddr),  96'(v.expAddr));
    endtask

    initial begin
        logic [95:0] prevDac;
        logic [95:0] all7ff;
        logic [95:0] expDac;
        logic [31:0] frm;
        int          validBefore;

        all7ff = {8{12'h7FF}};
        vecs[0]  = mk("init",      64'h08000001, 32, 1, 0, 0, '0, 1'b1, 4'h8, 4'h0);
        vecs[1]  = mk("wrUpd0",    64'h030ABC00, 32, 1, 0, 0,
                      dacVal(12'hABC, 0, 0, 0, 0, 0, 0, 0), 1'b1, 4'h3, 4'h0);
        vecs[2]  = mk("wrIn5",     64'h00512300, 32, 1, 0, 0,
                      dacVal(12'hABC, 0, 0, 0, 0, 0, 0, 0), 1'b1, 4'h0, 4'h5);
        vecs[3]  = mk("upd5",      64'h01500000, 32, 1, 0, 0,
                      dacVal(12'hABC, 0, 0, 0, 0, 12'h123, 0, 0), 1'b1, 4'h1, 4'h5);
        vecs[4]  = mk("bcast",     64'h03F7FF00, 32, 1, 0, 0, all7ff, 1'b1, 4'h3, 4'hF);
        vecs[5]  = mk("short20",   64'h3F123,    20, 0, 1, 0, all7ff, 1'b1, 4'h3, 4'hF);
        vecs[6]  = mk("long33",    64'h103555500,33, 0, 1, 0, all7ff, 1'b1, 4'h3, 4'hF);
        vecs[7]  = mk("badCmd",    64'h04000000, 32, 1, 0, 1, all7ff, 1'b1, 4'h4, 4'h0);
        vecs[8]  = mk("addrA",     64'h00A55500, 32, 1, 0, 0, all7ff, 1'b1, 4'h0, 4'hA);
        vecs[9]  = mk("wrIn1",     64'h00100100, 32, 1, 0, 0, all7ff, 1'b1, 4'h0, 4'h1);
        vecs[10] = mk("wrUpdAll2", 64'h0226AB00, 32, 1, 0, 0,
                      dacVal(12'h7FF, 12'h001, 12'h6AB, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF),
                      1'b1, 4'h2, 4'h2);
        vecs[11] = mk("refOff",    64'h08000000, 32, 1, 0, 0,
                      dacVal(12'h7FF, 12'h001, 12'h6AB, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF),
                      1'b0, 4'h8, 4'h0);

        rst = 1'b1; cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkValue("reset dac",      dacCode,          '0);
        checkValue("reset ref",      96'(refOn),       '0);
        checkValue("reset valid",    96'(frameValid),  '0);
        checkValue("reset err",      96'(frameErr),    '0);
        checkValue("reset cmdErr",   96'(cmdErr),      '0);
        checkValue("reset lastCmd",  96'(lastCmd),     '0);
        checkValue("reset lastAddr", 96'(lastAddr),    '0);

        prevDac = '0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], prevDac);
            prevDac = vecs[i].expDac;
        end

        // Last sclk fall and cs rise land in the same clk cycle
        sendBits(64'h03312300, 32, 1'b1);
        watchPulses();
        sclk = 1'b1;
        expDac = dacVal(12'h7FF, 12'h001, 12'h6AB, 12'h123, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF);
        checkValue("simul valid",   96'(obsValid), 96'd1);
        checkValue("simul err",     96'(obsErr),   96'd0);
        checkValue("simul dac",     dacCode,       expDac);
        checkValue("simul lastAddr",96'(lastAddr), 96'h3);

        // Back-to-back frames with cs high for only two clk cycles
        validBefore = validTotal;
        sendBits(64'h03400100, 32, 1'b0);
        #20;
        sendBits(64'h03500200, 32, 1'b0);
        watchPulses();
        expDac = dacVal(12'h7FF, 12'h001, 12'h6AB, 12'h123, 12'h001, 12'h002, 12'h7FF, 12'h7FF);
        checkValue("b2b validCount", 96'(validTotal - validBefore), 96'd2);
        checkValue("b2b dac",        dacCode,  expDac);
        checkValue("b2b lastAddr",   96'(lastAddr), 96'h5);

        // Reset pulse after bit 16 of a frame, then the frame completes
        frm = 32'h03612300;
        @(negedge clk);
        cs = 1'b0;
        for (int i = 31; i >= 16; i--) begin
            mosi = frm[i]; #40; sclk = 1'b0; #40; sclk = 1'b1;
        end
        rst = 1'b1;
        #10;
        rst = 1'b0;
        #1;
        checkValue("midRst dacNow", dacCode,    '0);
        checkValue("midRst refNow", 96'(refOn), '0);
        #9;
        for (int i = 15; i >= 0; i--) begin
            mosi = frm[i]; #40; sclk = 1'b0; #40; sclk = 1'b1;
        end
        #40;
        cs = 1'b1;
        watchPulses();
        checkValue("midRst valid",    96'(obsValid), 96'd0);
        checkValue("midRst err",      96'(obsErr),   96'd0);
        checkValue("midRst dac",      dacCode,       '0);
        checkValue("midRst lastCmd",  96'(lastCmd),  96'd0);
        checkValue("midRst lastAddr", 96'(lastAddr), 96'd0);

        sendBits(64'h03212300, 32, 1'b0);
        watchPulses();
        checkValue("postRst valid", 96'(obsValid), 96'd1);
        checkValue("postRst dac",   dacCode, dacVal(0, 0, 12'h123, 0, 0, 0, 0, 0));
        checkValue("postRst ref",   96'(refOn), 96'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
